// File: rtl/dispenser_pkg.sv
// Shared types for the drink dispenser scheduler.
// State encoding, drink codes and pour-length lookup.
package dispenser_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRIME = 3'd1,
        POUR  = 3'd2,
        DRIP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        D1   = 2'b01,
        D2   = 2'b10,
        D3   = 2'b11
    } drink_t;

    function automatic int pour_cycles(
        input drink_t code,
        input int     c1,
        input int     c2,
        input int     c3
    );
        case (code)
            D1:      return c1;
            D2:      return c2;
            D3:      return c3;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/dispense_timer.sv
// Loadable down-counter for the dispense phases.
// Holds at zero instead of wrapping.
module dispense_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dispenser_scheduler.sv
// Round-robin arbiter and dispense sequencer for one shared
// drink valve: PRIME, POUR, DRIP, DONE.
module dispenser_scheduler
    import dispenser_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int PRIME_CYC = 2,
    parameter int POUR1_CYC = 8,
    parameter int POUR2_CYC = 12,
    parameter int POUR3_CYC = 16,
    parameter int DRIP_CYC  = 3,
    parameter int CNT_W     = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] drink,
    input  logic               abort,
    output logic [N_REQ-1:0]   gnt,
    output logic               valve,
    output logic [1:0]         disp_sel,
    output logic               busy,
    output logic [N_REQ-1:0]   done,
    output logic [N_REQ-1:0]   err
);

    state_t           state, nstate;
    drink_t           sel_q, nsel;
    logic [1:0]       ptr, nptr;
    logic [1:0]       gidx, ngidx;
    logic             aborted, naborted;
    logic [N_REQ-1:0] ngnt, ndone, nerr;
    logic             nvalve;

    logic             t_load;
    logic [CNT_W-1:0] t_val;
    logic             t_zero;

    logic             pick_ok;
    logic [1:0]       pick_idx;
    logic [N_REQ-1:0] pick_oh;
    drink_t           pick_code;
    int               idx;

    function automatic logic [1:0] next_ptr(input logic [1:0] i);
        return (i == 2'(N_REQ - 1)) ? 2'd0 : i + 2'd1;
    endfunction

    dispense_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (t_load),
        .value (t_val),
        .zero  (t_zero)
    );

    // first requester at or after ptr, wrapping
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = 2'd0;
        idx      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!pick_ok && req[idx]) begin
                pick_ok  = 1'b1;
                pick_idx = 2'(idx);
            end
        end
        pick_oh   = N_REQ'(1) << pick_idx;
        pick_code = drink_t'(drink[{pick_idx, 1'b0} +: 2]);
    end

    always_comb begin
        nstate   = state;
        nsel     = sel_q;
        nptr     = ptr;
        ngidx    = gidx;
        naborted = aborted;
        ngnt     = gnt;
        nvalve   = valve;
        ndone    = '0;
        nerr     = '0;
        t_load   = 1'b0;
        t_val    = '0;
        unique case (state)
            IDLE: begin
                if (pick_ok) begin
                    if (pick_code != NONE) begin
                        nstate = PRIME;
                        ngnt   = pick_oh;
                        nsel   = pick_code;
                        ngidx  = pick_idx;
                        t_load = 1'b1;
                        t_val  = CNT_W'(PRIME_CYC - 1);
                    end else begin
                        nerr = pick_oh;
                        nptr = next_ptr(pick_idx);
                    end
                end
            end
            PRIME, POUR: begin
                if (abort) begin
                    nstate   = DRIP;
                    nvalve   = 1'b0;
                    naborted = 1'b1;
                    t_load   = 1'b1;
                    t_val    = CNT_W'(DRIP_CYC - 1);
                end else if (t_zero && state == PRIME) begin
                    nstate = POUR;
                    nvalve = 1'b1;
                    t_load = 1'b1;
                    t_val  = CNT_W'(pour_cycles(sel_q, POUR1_CYC,
                                 POUR2_CYC, POUR3_CYC) - 1);
                end else if (t_zero) begin
                    nstate = DRIP;
                    nvalve = 1'b0;
                    t_load = 1'b1;
                    t_val  = CNT_W'(DRIP_CYC - 1);
                end
            end
            DRIP: begin
                if (t_zero) begin
                    if (aborted) begin
                        nstate   = IDLE;
                        nerr     = gnt;
                        ngnt     = '0;
                        nsel     = NONE;
                        nptr     = next_ptr(gidx);
                        naborted = 1'b0;
                    end else begin
                        nstate = DONE;
                        ndone  = gnt;
                    end
                end
            end
            DONE: begin
                nstate = IDLE;
                ngnt   = '0;
                nsel   = NONE;
                nptr   = next_ptr(gidx);
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sel_q   <= NONE;
            ptr     <= 2'd0;
            gidx    <= 2'd0;
            aborted <= 1'b0;
            gnt     <= '0;
            valve   <= 1'b0;
            busy    <= 1'b0;
            done    <= '0;
            err     <= '0;
        end else begin
            state   <= nstate;
            sel_q   <= nsel;
            ptr     <= nptr;
            gidx    <= ngidx;
            aborted <= naborted;
            gnt     <= ngnt;
            valve   <= nvalve;
            busy    <= (nstate != IDLE);
            done    <= ndone;
            err     <= nerr;
        end
    end

    assign disp_sel = sel_q;

endmodule
